// File: rtl/up_axi_master.sv
// Single-beat AXI4-Lite master driven by a simple command/response port.
// One transaction in flight; a per-transaction cycle budget aborts a stalled slave.
module up_axi_master #(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         up_clk,
  input  logic                         up_rst,

  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                  cmd_wdata,

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_timeout,
  output logic                         busy,

  output logic                         m_axi_awvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  input  logic                         m_axi_awready,

  output logic                         m_axi_wvalid,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_wready,

  input  logic                         m_axi_bvalid,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_bready,

  output logic                         m_axi_arvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_arready,

  input  logic                         m_axi_rvalid,
  input  logic [1:0]                   m_axi_rresp,
  input  logic [31:0]                  m_axi_rdata,
  output logic                         m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t                         state;
  state_t                         state_next;
  logic                           abort;
  logic                           accept;
  logic                           active;
  logic                           timed_out;
  logic                           aw_hs;
  logic                           w_hs;
  logic                           b_hs;
  logic                           ar_hs;
  logic                           r_hs;
  logic                           aw_done;
  logic                           w_done;
  logic [15:0]                    tmo_count;
  logic [AXI_ADDRESS_WIDTH-1:0]   addr_q;
  logic [31:0]                    wdata_q;

  // cmd_ready is gated by reset so nothing is accepted while reset is held
  assign cmd_ready = (state == IDLE) && !up_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign active    = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
  assign timed_out = (tmo_count >= TMO_LIMIT);

  assign m_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_REQ);
  assign m_axi_rready  = (state == RD_RESP);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = 4'hF;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bvalid  && m_axi_bready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid  && m_axi_rready;

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A handshake that completes a phase wins over an expiring budget
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = cmd_wr ? WR_REQ : RD_REQ;
      WR_REQ: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
        else if (timed_out)                         abort      = 1'b1;
      end
      WR_RESP: begin
        if (b_hs)           state_next = DONE;
        else if (timed_out) abort      = 1'b1;
      end
      RD_REQ: begin
        if (ar_hs)          state_next = RD_RESP;
        else if (timed_out) abort      = 1'b1;
      end
      RD_RESP: begin
        if (r_hs)           state_next = DONE;
        else if (timed_out) abort      = 1'b1;
      end
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = DONE;
  end

  // Command capture, per-channel handshake tracking, budget counter and result capture
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmo_count   <= 16'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_rdata   <= 32'h0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else if (accept) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmo_count   <= 16'd0;
      addr_q      <= cmd_addr;
      wdata_q     <= cmd_wdata;
      rsp_rdata   <= 32'h0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      if (active && (tmo_count != 16'hFFFF)) tmo_count <= tmo_count + 16'd1;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs)  rsp_resp <= m_axi_bresp;
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
      if (abort) begin
        rsp_timeout <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= 32'h0;
      end
    end
  end

endmodule

// File: doc/up_axi_master.md
UP_AXI_MASTER -- requirements
Module: up_axi_master

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 16, AXI byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles allowed per transaction before abort; legal range 1..65535.
REQ-003 SHALL have one clock and a synchronous, active-high reset: up_clk in 1, clock for all logic; up_rst in 1, synchronous active-high reset.
REQ-004 cmd_valid in 1, command offered; cmd_ready out 1, command accepted when both high.
REQ-005 cmd_wr in 1, 1 = write, 0 = read.
REQ-006 cmd_addr in AXI_ADDRESS_WIDTH, byte address.
REQ-007 cmd_wdata in 32, write data.
REQ-008 rsp_valid out 1, result available; rsp_ready in 1, result consumed when both high.
REQ-009 rsp_rdata out 32, read data, 0 for writes.
REQ-010 rsp_resp out 2, captured BRESP/RRESP.
REQ-011 rsp_timeout out 1, transaction aborted by timeout.
REQ-012 busy out 1, high in any state other than IDLE.
REQ-013 m_axi_awvalid out 1, m_axi_awaddr out AXI_ADDRESS_WIDTH, m_axi_awprot out 3, m_axi_awready in 1.
REQ-014 m_axi_wvalid out 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wready in 1.
REQ-015 m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1.
REQ-016 m_axi_arvalid out 1, m_axi_araddr out AXI_ADDRESS_WIDTH, m_axi_arprot out 3, m_axi_arready in 1.
REQ-017 m_axi_rvalid in 1, m_axi_rresp in 2, m_axi_rdata in 32, m_axi_rready out 1.

Function
REQ-018 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-019 cmd_ready = 1 only in IDLE; on accept, cmd_addr and cmd_wdata are registered and the FSM goes to WR_REQ (cmd_wr = 1) or RD_REQ (cmd_wr = 0).
REQ-020 WR_REQ: awvalid and wvalid rise the cycle after accept; each drops independently the cycle after its own ready is sampled high; when both handshakes are done, go to WR_RESP; AW and W accepted in the same cycle is legal.
REQ-021 WR_RESP: bready = 1; on bvalid, capture bresp into rsp_resp and go to DONE.
REQ-022 RD_REQ: arvalid = 1 until arready is sampled, then go to RD_RESP.
REQ-023 RD_RESP: rready = 1; on rvalid, capture rdata and rresp, then go to DONE.
REQ-024 DONE: rsp_valid = 1, rsp outputs stable; on rsp_ready, go to IDLE; back-to-back commands are accepted earliest the cycle after DONE exits.
REQ-025 awprot = arprot = 3'b000 and wstrb = 4'hF constantly.
REQ-026 Address and data outputs SHALL hold the registered command value from accept until DONE.
REQ-027 A timeout counter SHALL clear on accept and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL on the next cycle drop all valid/ready outputs, set rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 32'h0, and enter DONE.
REQ-029 A handshake completing in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take precedence: normal progress, no timeout.
REQ-030 Minimum latency, accept to rsp_valid, with zero-wait slave: write 3 cycles, read 3 cycles.
REQ-031 A bvalid or rvalid arriving outside WR_RESP or RD_RESP SHALL be ignored (ready low).

Reset
REQ-032 up_rst high SHALL force IDLE, clear counter, and drive all m_axi valid/ready outputs, rsp_valid, rsp_timeout, busy to 0; rsp_rdata, rsp_resp to 0; cmd_ready = 0 during reset, 1 from the first cycle after.
REQ-033 Reset asserted mid-transaction SHALL abort on the next edge without issuing any response.

Verification
REQ-034 Write addr 16'h0040, data 32'h12345678, zero-wait slave -> single AW/W handshake with those values, bresp 0, rsp_valid 3 cycles after accept, rsp_timeout = 0.
REQ-035 Read addr 16'h0400, slave returns 32'hCAFE0001 after 5-cycle rvalid delay -> rsp_rdata = 32'hCAFE0001, rsp_resp = 0, arvalid held until arready.
REQ-036 Write with wready 4 cycles after awready -> awvalid drops after AW handshake, wvalid holds until wready, exactly one B accepted.
REQ-037 TIMEOUT_CYCLES = 8, slave never asserts arready -> rsp_timeout = 1, rsp_resp = 2'b10, arvalid low, busy high until rsp_ready.
REQ-038 Read with rsp_ready held low 10 cycles, then reset pulse -> rsp outputs stable for 10 cycles; after reset all outputs 0, and a new command is accepted.
